// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper
// used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int freq_hz, input int baud);
        return freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small power-of-two receive FIFO with valid/ready pop and an overflow strobe
// for bytes that arrive while full and no pop frees a slot.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_LVL = {(AW + 1){1'b0}};

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             full_s;
    logic             empty_s;
    logic             do_pop_s;
    logic             do_push_s;

    // Handshake qualification; a pop on a full FIFO frees the slot for a same-cycle push
    always_comb begin
        full_s    = (level_r == FULL_LVL);
        empty_s   = (level_r == ZERO_LVL);
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
        overflow  = push & full_s & ~do_pop_s;
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= ZERO_LVL;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW + 1)'(1'b1);
                2'b01:   level_r <= level_r - (AW + 1)'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign data  = mem_r[rd_ptr_r];
    assign valid = ~empty_s;
    assign level = level_r;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: RXD synchroniser, mid-bit sampling FSM, receive FIFO and
// sticky frame-error / overrun status flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    input  logic                          i_clr_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    if (CLKS_PER_BIT < 8) begin : g_cpb_check
        $error("uart_receiver: CLKS_PER_BIT must be at least 8");
    end

    uart_rx_state_t state_r;
    uart_rx_state_t state_nxt_s;

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tick_s;
    logic             last_bit_s;
    logic             load_half_s;
    logic             load_full_s;
    logic             clr_idx_s;
    logic             inc_idx_s;
    logic             shift_en_s;
    logic             push_s;
    logic             frame_err_set_s;
    logic             overflow_s;
    logic             frame_err_r;
    logic             overrun_r;

    // Two-flop synchroniser; idles high so reset does not fake a start bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s       = rx_sync_r;
    assign tick_s     = (cnt_r == CNT_ZERO);
    assign last_bit_s = (bit_idx_r == 3'd7);

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rx_s) state_nxt_s = START;
                else       state_nxt_s = IDLE;
            end
            START: begin
                if (tick_s) state_nxt_s = rx_s ? IDLE : DATA;
                else        state_nxt_s = START;
            end
            DATA: begin
                if (tick_s && last_bit_s) state_nxt_s = STOP;
                else                      state_nxt_s = DATA;
            end
            STOP: begin
                if (tick_s) state_nxt_s = rx_s ? IDLE : BREAK;
                else        state_nxt_s = STOP;
            end
            BREAK: begin
                if (rx_s) state_nxt_s = IDLE;
                else      state_nxt_s = BREAK;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM datapath controls
    always_comb begin
        load_half_s     = 1'b0;
        load_full_s     = 1'b0;
        clr_idx_s       = 1'b0;
        inc_idx_s       = 1'b0;
        shift_en_s      = 1'b0;
        push_s          = 1'b0;
        frame_err_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_half_s = ~rx_s;
            end
            START: begin
                if (tick_s && !rx_s) begin
                    load_full_s = 1'b1;
                    clr_idx_s   = 1'b1;
                end else begin
                    load_full_s = 1'b0;
                    clr_idx_s   = 1'b0;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_en_s  = 1'b1;
                    load_full_s = 1'b1;
                    inc_idx_s   = ~last_bit_s;
                end else begin
                    shift_en_s  = 1'b0;
                    load_full_s = 1'b0;
                    inc_idx_s   = 1'b0;
                end
            end
            STOP: begin
                push_s          = tick_s & rx_s;
                frame_err_set_s = tick_s & ~rx_s;
            end
            BREAK: begin
                push_s = 1'b0;
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Baud counter, bit index and LSB-first shift register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            if (load_half_s)      cnt_r <= CNT_HALF;
            else if (load_full_s) cnt_r <= CNT_FULL;
            else if (!tick_s)     cnt_r <= cnt_r - CNT_W'(1'b1);
            else                  cnt_r <= cnt_r;

            if (clr_idx_s)      bit_idx_r <= 3'd0;
            else if (inc_idx_s) bit_idx_r <= bit_idx_r + 3'd1;
            else                bit_idx_r <= bit_idx_r;

            if (shift_en_s) shift_r <= {rx_s, shift_r[7:1]};
            else            shift_r <= shift_r;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (i_ready),
        .data      (o_data),
        .valid     (o_valid),
        .level     (o_level),
        .overflow  (overflow_s)
    );

    // Sticky status flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (frame_err_set_s) frame_err_r <= 1'b1;
            else if (i_clr_err)  frame_err_r <= 1'b0;
            else                 frame_err_r <= frame_err_r;

            if (overflow_s)     overrun_r <= 1'b1;
            else if (i_clr_err) overrun_r <= 1'b0;
            else                overrun_r <= overrun_r;
        end
    end

    assign o_frame_err = frame_err_r;
    assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 32 clocks per bit: expected bytes are
// queued as frames are driven and compared when popped from the DUT.
module tb_uart_receiver;

    localparam int CLK_HZ = 3_686_400;
    localparam int BAUD   = 115_200;
    localparam int CPB    = 32;
    localparam int FRAME  = 10 * CPB;
    // Stop-bit mid-sample (push) edge, counted in negedges from the start-bit drive
    localparam int PUSH_M = 306;

    logic       clk = 1'b0;
    logic       resetn;
    logic       i_rx;
    logic       i_ready;
    logic       i_clr_err;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_level;
    logic       o_frame_err;
    logic       o_overrun;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    uart_receiver #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_level     (o_level),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .i_clr_err   (i_clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_head(input string tag);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
        check(tag, 32'(o_data), e);
    endtask

    // Drive frame positions [m_from, m_to); optional in-frame pop / clear pulse at index m
    task automatic send_frame(input logic [7:0] b, input logic stop, input int m_from,
                              input int m_to, input int pop_at, input int clr_at);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int m = m_from; m < m_to; m++) begin
            i_rx = fr[4'(m / CPB)];
            if (m == pop_at) begin
                check("pop_in_frame_valid", 32'(o_valid), 32'd1);
                pop_head("pop_in_frame_data");
                i_ready = 1'b1;
            end else begin
                i_ready = 1'b0;
            end
            i_clr_err = (m == clr_at) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        i_ready   = 1'b0;
        i_clr_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 0, FRAME, -1, -1);
    endtask

    task automatic pop_check(input string tag);
        int n;
        n = 0;
        while (!o_valid && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        pop_head(tag);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_level"}, 32'(o_level), 32'd0);
        check({tag, "_data"}, 32'(o_data), 32'd0);
        check({tag, "_ferr"}, 32'(o_frame_err), 32'd0);
        check({tag, "_ovr"}, 32'(o_overrun), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rx      = 1'b1;
        i_ready   = 1'b0;
        i_clr_err = 1'b0;
        resetn    = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        resetn = 1'b1;
        idle(4);

        // Single byte: nothing visible before the stop sample, then one entry
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 0, 9 * CPB, -1, -1);
        check("t1_not_yet_valid", 32'(o_valid), 32'd0);
        send_frame(8'hA5, 1'b1, 9 * CPB, FRAME, -1, -1);
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_level", 32'(o_level), 32'd1);
        check("t1_ferr", 32'(o_frame_err), 32'd0);
        check("t1_ovr", 32'(o_overrun), 32'd0);
        pop_check("t1_data");
        check("t1_level_after", 32'(o_level), 32'd0);

        // Back-to-back frames with the first byte popped during the second frame
        exp_q.push_back(8'h00);
        send_byte(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 0, FRAME, 5, -1);
        pop_check("t2_ff");
        check("t2_level", 32'(o_level), 32'd0);

        // Short low glitch is rejected at the mid-start sample
        i_rx = 1'b0;
        idle(10);
        i_rx = 1'b1;
        idle(3 * CPB);
        check("t3_valid", 32'(o_valid), 32'd0);
        check("t3_level", 32'(o_level), 32'd0);
        check("t3_ferr", 32'(o_frame_err), 32'd0);
        exp_q.push_back(8'h96);
        send_byte(8'h96);
        pop_check("t3_recover");

        // Bad stop bit followed by a held-low line: one frame error only
        send_frame(8'h3C, 1'b0, 0, FRAME, -1, -1);
        check("t4_ferr_set", 32'(o_frame_err), 32'd1);
        check("t4_no_push", 32'(o_valid), 32'd0);
        i_clr_err = 1'b1;
        idle(1);
        i_clr_err = 1'b0;
        idle(1);
        check("t4_ferr_clr", 32'(o_frame_err), 32'd0);
        idle(19 * CPB);
        check("t4_ferr_held_low", 32'(o_frame_err), 32'd0);
        i_rx = 1'b1;
        idle(2 * CPB);
        check("t4_ferr_release", 32'(o_frame_err), 32'd0);
        check("t4_level", 32'(o_level), 32'd0);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3);
        pop_check("t4_recover");

        // Overrun: fifth byte dropped; a clear on the drop cycle loses to the set
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 0, FRAME, -1, (b == 5) ? PUSH_M : -1);
        end
        check("t5_level_full", 32'(o_level), 32'd4);
        check("t5_ovr_set", 32'(o_overrun), 32'd1);
        for (int i = 0; i < 4; i++) pop_check("t5_pop");
        check("t5_level_empty", 32'(o_level), 32'd0);
        i_clr_err = 1'b1;
        idle(1);
        i_clr_err = 1'b0;
        idle(1);
        check("t5_ovr_clr", 32'(o_overrun), 32'd0);

        // Pop coinciding with the push into a full FIFO: both happen, no overrun
        for (int b = 8'h11; b <= 8'h15; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 0, FRAME, (b == 8'h15) ? PUSH_M : -1, -1);
        end
        check("t5b_ovr", 32'(o_overrun), 32'd0);
        check("t5b_level", 32'(o_level), 32'd4);
        for (int i = 0; i < 4; i++) pop_check("t5b_pop");
        check("t5b_level_empty", 32'(o_level), 32'd0);

        // Reset mid-frame discards FIFO contents and the partial byte
        exp_q.push_back(8'h77);
        send_byte(8'h77);
        send_frame(8'h33, 1'b1, 0, 5 * CPB + 10, -1, -1);
        resetn = 1'b0;
        i_rx   = 1'b1;
        exp_q.delete();
        idle(3);
        check_reset_outputs("t6_reset");
        resetn = 1'b1;
        idle(2 * CPB);
        check("t6_no_partial", 32'(o_valid), 32'd0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A);
        check("t6_level", 32'(o_level), 32'd1);
        pop_check("t6_data");
        check("t6_level_after", 32'(o_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
